ram_sdp: RTL

- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both clocked on CLK.
- Successor to the 16x8 combinational register RAM. Adds clocked writes, registered read data with a valid flag, and a hardware clear sequencer that zeroes every word after reset or on request.
- Used as the general scratch/data memory beside the CPU datapath.

---
 rtl/ram_sdp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_sdp.sv
// Simple-dual-port synchronous RAM with registered read data and a hardware clear sequencer.
// Optional macro RAM_BYPASS_EN selects write-first same-address behaviour (default read-first).
module ram_sdp #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned OUT_REG = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLEAR,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              READY,
  output logic              ERR
);

  localparam int unsigned     MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [MEM_AW-1:0] mem_idx;
  logic [DATA_W-1:0] mem_val;

  logic              wr_fire, wr_ok, rd_fire, rd_ok, bypass;
  logic [DATA_W-1:0] rd_word;
  logic              vld1_q, err_q;
  logic [DATA_W-1:0] data1_q;

  assign READY   = (state_q == RUN);
  assign wr_fire = READY & WR_EN;
  assign rd_fire = READY & RD_EN;
  assign wr_ok   = ({1'b0, WR_ADDR} < DEPTH_L);
  assign rd_ok   = ({1'b0, RD_ADDR} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (CLEAR) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (CLEAR) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single physical write port: the clear sequencer owns it during INIT.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = WR_ADDR[MEM_AW-1:0];
    mem_val = WR_DATA;
    if (state_q == INIT) begin
      mem_we  = 1'b1;
      mem_idx = cnt_q[MEM_AW-1:0];
      mem_val = '0;
    end else if (wr_fire && wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_val;
    end
  end

`ifdef RAM_BYPASS_EN
  assign bypass = wr_fire && wr_ok && (WR_ADDR == RD_ADDR);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = bypass ? WR_DATA : mem_q[RD_ADDR[MEM_AW-1:0]];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld1_q  <= 1'b0;
      data1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld1_q <= rd_fire;
      err_q  <= (wr_fire & ~wr_ok) | (rd_fire & ~rd_ok);
      if (rd_fire) begin
        data1_q <= rd_word;
      end
    end
  end

  assign ERR = err_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              vld2_q;
      logic [DATA_W-1:0] data2_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          vld2_q  <= 1'b0;
          data2_q <= '0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) begin
            data2_q <= data1_q;
          end
        end
      end
      assign RD_VALID = vld2_q;
      assign RD_DATA  = data2_q;
    end else begin : g_noreg
      assign RD_VALID = vld1_q;
      assign RD_DATA  = data1_q;
    end
  endgenerate

endmodule
